// File: rtl/halut_pkg.sv
// Shared HALUT constants and types: default codebook geometry, LUT entry width
// and the LUT address type.
package halut_pkg;

  localparam int unsigned KDefault             = 16;
  localparam int unsigned CDefault             = 32;
  localparam int unsigned DataTypeWidthDefault = 16;

  localparam int unsigned TreeDepthDefault    = $clog2(KDefault);
  localparam int unsigned CAddrWidthDefault   = $clog2(CDefault);
  localparam int unsigned LutAddrWidthDefault = CAddrWidthDefault + TreeDepthDefault;

  // The LUT is addressed as {codebook index, prototype index}.
  typedef logic [LutAddrWidthDefault-1:0] lut_addr_t;

endpackage

// File: rtl/scm.sv
// Standard-cell LUT memory holding C*K entries.
// Write is synchronous, read is combinational, and reset clears every entry.
module scm #(
  parameter int unsigned C             = 32,
  parameter int unsigned K             = 16,
  parameter int unsigned DataTypeWidth = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                we_i,
  input  logic [$clog2(C)+$clog2(K)-1:0]      waddr_i,
  input  logic [DataTypeWidth-1:0]            wdata_i,
  input  logic [$clog2(C)+$clog2(K)-1:0]      raddr_i,
  output logic [DataTypeWidth-1:0]            rdata_o
);

  localparam int unsigned Depth = C * K;

  logic [DataTypeWidth-1:0] r_mem [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/halut_decoder.sv
// HALUT decoder: accumulates one LUT entry per codebook and emits a row sum every C inputs.
// Define HALUT_DECODER_SATURATE_EN to clamp the row sum instead of wrapping it.
module halut_decoder
  import halut_pkg::*;
#(
  parameter int unsigned K             = KDefault,
  parameter int unsigned C             = CDefault,
  parameter int unsigned DataTypeWidth = DataTypeWidthDefault
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [$clog2(C)-1:0]               c_addr_i,
  input  logic [$clog2(K)-1:0]               k_addr_i,
  input  logic                               valid_i,
  input  logic [$clog2(C)+$clog2(K)-1:0]     waddr_i,
  input  logic [DataTypeWidth-1:0]           wdata_i,
  input  logic                               we_i,
  input  logic                               clear_i,
  output logic [DataTypeWidth-1:0]           result_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               overflow_o
);

  localparam int unsigned TreeDepth    = $clog2(K);
  localparam int unsigned CAddrWidth   = $clog2(C);
  localparam int unsigned LutAddrWidth = CAddrWidth + TreeDepth;
  localparam int unsigned AccWidth     = DataTypeWidth + CAddrWidth;

  localparam logic [CAddrWidth-1:0] LastIdx = CAddrWidth'(C - 1);

  logic [LutAddrWidth-1:0]  w_raddr;
  logic [DataTypeWidth-1:0] w_rdata;
  logic [AccWidth-1:0]      w_sum;
  logic [DataTypeWidth-1:0] w_res;
  logic                     w_complete;
  logic                     w_last;

  logic [DataTypeWidth-1:0] r_rdata;
  logic                     r_v1;
  logic                     r_last1;
  logic [DataTypeWidth-1:0] r_data2;
  logic                     r_v2;
  logic                     r_last2;
  logic [CAddrWidth-1:0]    r_count;
  logic [AccWidth-1:0]      r_acc;
  logic [DataTypeWidth-1:0] r_result;
  logic                     r_valid;
  logic                     r_overflow;

  assign w_raddr = {c_addr_i, k_addr_i};
  assign w_last  = (r_count == LastIdx);

  scm #(
    .C             (C),
    .K             (K),
    .DataTypeWidth (DataTypeWidth)
  ) u_scm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (we_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata)
  );

  // Read register samples the array before a same-edge write lands, so reads see old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_data2 <= '0;
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
    end else begin
      r_rdata <= w_rdata;
      r_v1    <= valid_i & ~clear_i;
      r_last1 <= w_last;
      r_data2 <= r_rdata;
      r_v2    <= r_v1 & ~clear_i;
      r_last2 <= r_last1;
    end
  end

  // Row position counter; completion is decided purely by this count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (valid_i) begin
      r_count <= w_last ? '0 : r_count + CAddrWidth'(1);
    end
  end

  assign w_sum      = r_acc + {{CAddrWidth{r_data2[DataTypeWidth-1]}}, r_data2};
  assign w_complete = r_v2 & r_last2 & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (clear_i) begin
      r_acc <= '0;
    end else if (r_v2) begin
      r_acc <= r_last2 ? '0 : w_sum;
    end
  end

`ifdef HALUT_DECODER_SATURATE_EN
  // Out of range when the bits above the result sign are not a pure sign extension.
  always_comb begin
    w_res = w_sum[DataTypeWidth-1:0];
    if (w_sum[AccWidth-1:DataTypeWidth-1] != {(CAddrWidth + 1){w_sum[AccWidth-1]}}) begin
      w_res = w_sum[AccWidth-1] ? {1'b1, {(DataTypeWidth - 1){1'b0}}}
                                : {1'b0, {(DataTypeWidth - 1){1'b1}}};
    end
  end
`else
  assign w_res = w_sum[DataTypeWidth-1:0];
`endif

  // A completed row is dropped (and flagged) while an unconsumed result is still held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_complete && !(r_valid && !ready_i)) begin
        r_result <= w_res;
        r_valid  <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_complete && r_valid && !ready_i) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign result_o   = r_result;
  assign valid_o    = r_valid;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_halut_decoder.sv
// Self-checking bench for halut_decoder (C=4, K=16, 16-bit entries) against a
// row-sum reference model; honours HALUT_DECODER_SATURATE_EN.
module tb_halut_decoder;

  localparam int unsigned K  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned DW = 16;

  logic          clk_i;
  logic          rst_ni;
  logic [1:0]    c_addr_i;
  logic [3:0]    k_addr_i;
  logic          valid_i;
  logic [5:0]    waddr_i;
  logic [DW-1:0] wdata_i;
  logic          we_i;
  logic          clear_i;
  logic [DW-1:0] result_o;
  logic          valid_o;
  logic          ready_i;
  logic          overflow_o;

  halut_decoder #(
    .K             (K),
    .C             (C),
    .DataTypeWidth (DW)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .c_addr_i   (c_addr_i),
    .k_addr_i   (k_addr_i),
    .valid_i    (valid_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .we_i       (we_i),
    .clear_i    (clear_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int            lut_m [C][K];
  longint        row_sum;
  int            row_cnt;
  logic [DW-1:0] exp_q [$];
  bit            auto_mon;
  int            n_checks;
  int            n_err;

  // Row sum formatted as the result port presents it.
  function automatic logic [DW-1:0] fmt(input longint s);
`ifdef HALUT_DECODER_SATURATE_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, update the model (read before write), step past the edge, monitor.
  task automatic cyc(input bit v, input int c, input int k,
                     input bit we, input int wa, input logic [DW-1:0] wd, input bit clr);
    valid_i  = v;
    c_addr_i = 2'(c);
    k_addr_i = 4'(k);
    we_i     = we;
    waddr_i  = 6'(wa);
    wdata_i  = wd;
    clear_i  = clr;
    if (clr) begin
      row_sum = 0;
      row_cnt = 0;
    end else if (v) begin
      row_sum += longint'(lut_m[c][k]);
      row_cnt++;
      if (row_cnt == int'(C)) begin
        exp_q.push_back(fmt(row_sum));
        row_sum = 0;
        row_cnt = 0;
      end
    end
    if (we) lut_m[wa / int'(K)][wa % int'(K)] = int'($signed(wd));
    @(posedge clk_i);
    #1;
    if (auto_mon && valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(valid_o), 32'd0);
      end else begin
        chk("stream_result", 32'(result_o), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic send(input int c, input int k);
    cyc(1'b1, c, k, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    cyc(1'b0, 0, 0, 1'b1, a, d, 1'b0);
  endtask

  task automatic send_rand_row();
    for (int i = 0; i < int'(C); i++) send($urandom_range(3, 0), $urandom_range(15, 0));
  endtask

  // Bounded wait for the next result, then compare against the model.
  task automatic expect_result(input string tag);
    int n;
    logic [DW-1:0] e;
    n = 0;
    while (!valid_o && n < 8) begin
      idle();
      n++;
    end
    if (!valid_o) begin
      chk({tag, "_timeout"}, 32'(valid_o), 32'd1);
      exp_q.delete();
    end else begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk(tag, 32'(result_o), 32'(e));
      idle();
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    auto_mon = 1'b0;
    row_sum  = 0;
    row_cnt  = 0;
    rst_ni   = 1'b0;
    ready_i  = 1'b1;
    valid_i  = 1'b0;
    c_addr_i = '0;
    k_addr_i = '0;
    we_i     = 1'b0;
    waddr_i  = '0;
    wdata_i  = '0;
    clear_i  = 1'b0;
    for (int c = 0; c < int'(C); c++) for (int k = 0; k < int'(K); k++) lut_m[c][k] = 0;
    #3;
    chk("reset_result", 32'(result_o), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_overflow", 32'(overflow_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill LUT[c][k] = c*16 + k.
    for (int a = 0; a < int'(C * K); a++) wr(a, DW'(a));

    // Single row, exact latency and one-cycle valid pulse.
    for (int i = 0; i < 4; i++) send(i, i + 1);
    idle();
    chk("lat_t1_valid", 32'(valid_o), 32'd0);
    idle();
    chk("lat_t2_valid", 32'(valid_o), 32'd1);
    chk("row_106", 32'(result_o), 32'd106);
    idle();
    chk("lat_t3_valid", 32'(valid_o), 32'd0);
    exp_q.delete();

    // Backpressure: second row is dropped and overflow becomes sticky.
    ready_i = 1'b0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) send(i, i + 1);
    for (int i = 0; i < 3; i++) idle();
    chk("bp_valid_held", 32'(valid_o), 32'd1);
    chk("bp_result_held", 32'(result_o), 32'd106);
    chk("bp_overflow", 32'(overflow_o), 32'd1);
    ready_i = 1'b1;
    idle();
    chk("bp_consumed", 32'(valid_o), 32'd0);
    for (int i = 0; i < 3; i++) idle();
    chk("bp_no_second", 32'(valid_o), 32'd0);
    chk("bp_overflow_sticky", 32'(overflow_o), 32'd1);
    exp_q.delete();

    // All entries at +max: clamp or wrap.
    for (int a = 0; a < int'(C * K); a++) wr(a, 16'h7FFF);
    send_rand_row();
    expect_result("max_row");

    // Asynchronous reset in the middle of a row.
    for (int a = 0; a < int'(C * K); a++) wr(a, DW'($urandom));
    send(0, 1);
    send(1, 2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_result", 32'(result_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_overflow", 32'(overflow_o), 32'd0);
    for (int c = 0; c < int'(C); c++) for (int k = 0; k < int'(K); k++) lut_m[c][k] = 0;
    row_sum = 0;
    row_cnt = 0;
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    send_rand_row();
    expect_result("lut_cleared_row");
    for (int a = 0; a < int'(C * K); a++) wr(a, DW'($urandom));
    send_rand_row();
    expect_result("post_reset_row");

    // Clear aborts a partial row and wins over a same-cycle input.
    send(1, 3);
    send(2, 7);
    cyc(1'b1, 3, 9, 1'b0, 0, '0, 1'b1);
    send_rand_row();
    expect_result("clear_row");

    // Same-cycle write and read of LUT[0][0] returns the old value.
    wr(0, 16'd9);
    cyc(1'b1, 0, 0, 1'b1, 0, 16'd5, 1'b0);
    for (int i = 0; i < 3; i++) send($urandom_range(3, 1), $urandom_range(15, 0));
    expect_result("rw_old_row");
    send(0, 0);
    for (int i = 0; i < 3; i++) send($urandom_range(3, 1), $urandom_range(15, 0));
    expect_result("rw_new_row");

    // Random back-to-back traffic with interleaved LUT writes.
    auto_mon = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cyc(($urandom_range(3, 0) != 0), $urandom_range(3, 0), $urandom_range(15, 0),
          ($urandom_range(3, 0) == 0), $urandom_range(63, 0), DW'($urandom), 1'b0);
    end
    for (int n = 0; n < 6; n++) idle();
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
